// File: rtl/cpu_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_regfile_wb_arbiter
//
// Shares the register file's single write port between NREQ writeback sources
// (ALU, load unit, CSR unit, ...). A round-robin arbiter picks one requester per
// cycle. The winning write is registered and presented to the regfile on the
// following cycle. Writes to x0 complete their handshake but never raise
// rf_rd_write_en.
//
// Handshake: requester i holds req_valid[i] together with a stable
// req_rd_addr/req_rd_data slice until it sees req_ready[i]=1 in the same cycle.
// The write is accepted at that posedge. req_ready is one-hot or zero, and
// req_ready[i] is never 1 unless req_valid[i] is 1. There is no backpressure
// from the regfile.
//
// Ports
//   clk            in   1          clock, all state updates on posedge
//   reset          in   1          synchronous active-high reset
//   hold           in   1          pipeline stall, blocks every grant this cycle
//   req_valid      in   NREQ       requester i has a write pending
//   req_ready      out  NREQ       one-hot grant, write of requester i accepted
//   req_rd_addr    in   NREQ*5     dest register of requester i, [5*i +: 5]
//   req_rd_data    in   NREQ*XLEN  write data of requester i, [XLEN*i +: XLEN]
//   rf_rd_addr     out  5          regfile write address (registered)
//   rf_rd_data     out  XLEN       regfile write data (registered)
//   rf_rd_write_en out  1          regfile write enable (registered)
//   grant_id       out  IDW        requester whose write is on rf_* this cycle
// -----------------------------------------------------------------------------
module cpu_regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 3,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_rd_addr,
    input  logic [NREQ*XLEN-1:0] req_rd_data,
    output logic [4:0]           rf_rd_addr,
    output logic [XLEN-1:0]      rf_rd_data,
    output logic                 rf_rd_write_en,
    output logic [IDW-1:0]       grant_id
);

    // Registered state
    logic [IDW-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [4:0]      addr_q,    addr_d;
    logic [XLEN-1:0] data_q,    data_d;
    logic [IDW-1:0]  gid_q,     gid_d;
    logic            we_q,      we_d;

    // Arbitration results
    logic            found;
    logic [IDW-1:0]  winner;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_data;
    logic            accept;

    // Round-robin scan starting at rr_ptr_q. rr_ptr_q < NREQ and k < NREQ, so
    // the sum stays below 2*NREQ and one conditional subtract is enough.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Select the winner's address and data.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == winner) begin
                win_addr = req_rd_addr[5*i +: 5];
                win_data = req_rd_data[XLEN*i +: XLEN];
            end
        end
    end

    // Grant is suppressed during stall and reset; found already implies that
    // the winner's valid bit is set.
    always_comb begin
        req_ready = '0;
        if (found && !hold && !reset) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        gid_d    = gid_q;
        we_d     = 1'b0;
        if (accept) begin
            addr_d   = win_addr;
            data_d   = win_data;
            gid_d    = winner;
            // x0 writes load the data path but never enable the regfile.
            we_d     = (win_addr != 5'd0);
            rr_ptr_d = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            gid_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            we_q     <= we_d;
        end
    end

    assign rf_rd_addr = addr_q;
    assign rf_rd_data = data_q;
    assign grant_id   = gid_q;
    // A write registered just before reset would otherwise reach the regfile
    // at the reset edge. Masking it here discards the pending write.
    assign rf_rd_write_en = we_q & ~reset;

endmodule

// File: tb/tb_cpu_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_regfile_wb_arbiter
//
// Self-checking bench for cpu_regfile_wb_arbiter with NREQ=3 and XLEN=32.
// A behavioural model tracks the round-robin pointer, the registered write and
// a 32-entry register file. A shadow regfile is written from the DUT's rf_*
// port and compared against the model. Expected regfile writes are queued in
// exp_q and matched in order.
// -----------------------------------------------------------------------------
module tb_cpu_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd_addr;
  logic [NREQ*XLEN-1:0] req_rd_data;
  logic [4:0]           rf_rd_addr;
  logic [XLEN-1:0]      rf_rd_data;
  logic                 rf_rd_write_en;
  logic [IDW-1:0]       grant_id;

  cpu_regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rd_addr    (req_rd_addr),
    .req_rd_data    (req_rd_data),
    .rf_rd_addr     (rf_rd_addr),
    .rf_rd_data     (rf_rd_data),
    .rf_rd_write_en (rf_rd_write_en),
    .grant_id       (grant_id)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_ptr = 0;
  bit              m_pend = 1'b0;
  bit              m_known = 1'b0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_data = '0;
  int              m_gid = 0;
  logic [XLEN-1:0] mrf [32];
  logic [XLEN-1:0] srf [32];
  logic [NREQ-1:0] last_grant;

  // Expected regfile writes, {addr, data}, in issue order.
  logic [36:0] exp_q [$];

  // Shadow regfile fed by the DUT write port. x0 is stored literally so a
  // leaked x0 write is visible.
  always @(posedge clk) begin
    if (rf_rd_write_en === 1'b1) begin
      srf[rf_rd_addr] = rf_rd_data;
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", {rf_rd_addr, rf_rd_data}, 37'd0);
      end else begin
        check_eq("wr_stream", {rf_rd_addr, rf_rd_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1. Applies one cycle of inputs, checks the cycle, updates
  // the model for the coming edge, then advances to the next posedge+1.
  task automatic step(input logic rst, input logic hld, input logic [NREQ-1:0] v,
                      input logic [NREQ*5-1:0] a, input logic [NREQ*XLEN-1:0] d);
    int win;
    int idx;
    logic [NREQ-1:0] exp_rdy;
    reset       = rst;
    hold        = hld;
    req_valid   = v;
    req_rd_addr = a;
    req_rd_data = d;
    #2;
    win = -1;
    if (!rst && !hld) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    exp_rdy = (win < 0) ? '0 : NREQ'(1 << win);
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("rf_we", rf_rd_write_en, m_pend && !rst);
    if (m_known) begin
      check_eq("rf_addr", rf_rd_addr, m_addr);
      check_eq("rf_data", rf_rd_data, m_data);
      check_eq("grant_id", grant_id, m_gid);
    end
    last_grant = exp_rdy;
    // Effects of the coming edge.
    if (m_pend && !rst) mrf[m_addr] = m_data;
    if (rst) begin
      if (m_pend) void'(exp_q.pop_back());
      m_pend  = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_gid   = 0;
      m_ptr   = 0;
      m_known = 1'b1;
    end else if (win >= 0) begin
      m_addr = a[5*win +: 5];
      m_data = d[XLEN*win +: XLEN];
      m_gid  = win;
      m_pend = (m_addr != 5'd0);
      if (m_pend) exp_q.push_back({m_addr, m_data});
      m_ptr  = (win + 1) % NREQ;
    end else begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [NREQ*5-1:0]    RR_A = {5'd7, 5'd6, 5'd5};
  localparam logic [NREQ*XLEN-1:0] RR_D = {32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555};

  logic [NREQ-1:0]      pv;
  logic [NREQ*5-1:0]    pa;
  logic [NREQ*XLEN-1:0] pd;
  logic                 r_rst;
  logic                 r_hld;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mrf[i] = '0;
      srf[i] = '0;
    end
    reset = 1'b1; hold = 1'b0; req_valid = '0; req_rd_addr = '0; req_rd_data = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles with every requester valid.
    step(1'b1, 1'b0, 3'b111, RR_A, RR_D);
    step(1'b1, 1'b0, 3'b111, RR_A, RR_D);

    // Continuous round robin: 0,1,2,0,1,2 with no bubbles.
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 3'b111, RR_A, RR_D);

    // Single write of x1 from req0.
    step(1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd1}, {32'd0, 32'd0, 32'h1234_5678});
    idle();
    idle();
    check_eq("x1", srf[1], 32'h1234_5678);
    check_eq("x5", srf[5], 32'h5555_5555);
    check_eq("x6", srf[6], 32'hAAAA_AAAA);
    check_eq("x7", srf[7], 32'hFFFF_FFFF);

    // x0 write from req1 with the pointer at 1: handshake only.
    step(1'b0, 1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0});
    idle();
    idle();
    check_eq("x0", srf[0], 32'd0);
    step(1'b0, 1'b0, 3'b111, RR_A, RR_D);   // next grant goes to req2
    idle();

    // Hold for three cycles with req0 and req2 valid, then release.
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 3'b101, RR_A, RR_D);
    step(1'b0, 1'b0, 3'b101, RR_A, RR_D);
    step(1'b0, 1'b0, 3'b100, RR_A, RR_D);

    // Reset the cycle after accepting an x8 write from req2.
    step(1'b0, 1'b0, 3'b100, {5'd8, 5'd0, 5'd0}, {32'hFFFF_FFFF, 32'd0, 32'd0});
    step(1'b1, 1'b0, 3'b000, '0, '0);
    idle();
    check_eq("x8", srf[8], 32'd0);
    step(1'b0, 1'b0, 3'b111, RR_A, RR_D);   // pointer back at 0
    idle();

    // Randomized traffic. Requesters keep addr/data stable until granted.
    pv = '0; pa = '0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i]           = 1'b1;
          pa[5*i +: 5]    = 5'($urandom_range(0, 7));
          pd[XLEN*i +: XLEN] = $urandom;
        end
      end
      r_rst = ($urandom_range(0, 49) == 0);
      r_hld = ($urandom_range(0, 6) == 0);
      step(r_rst, r_hld, pv, pa, pd);
      pv = pv & ~last_grant;
    end

    // Drain and compare the whole register file.
    for (int c = 0; c < 3; c++) idle();
    for (int i = 0; i < 32; i++) begin
      check_eq($sformatf("rf_x%0d", i), srf[i], mrf[i]);
    end
    check_eq("wr_q_drain", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
